// File: rtl/hud_pkg.sv
// Shared HUD definitions for the lives-icon path.
//   lives_scan_t : scan FSM state encoding (IDLE/FETCH/DRAW/GAP)
//   GLYPH_W/H    : lives-icon glyph geometry (8x8)
//   glyph_row_t  : one glyph ROM row, MSB = leftmost pixel
package hud_pkg;

   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 8;

   typedef logic [7:0] glyph_row_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAW  = 2'd2,
      GAP   = 2'd3
   } lives_scan_t;

endpackage

// File: rtl/lives_icon_renderer_if.sv
// Bundle between the video/game side and the lives-icon renderer.
//   master : pixel scan (pixel_valid, DrawX, DrawY), frame_start,
//            life_lost/life_gain pulses, glyph ROM data (font_data);
//            observes font_addr, icon_on, lives, game_over, scan_state.
//   slave  : the renderer, mirror image of master.
// Qualifier semantics: pixel_valid has no ready partner. A pixel (DrawX,
// DrawY) is consumed on every rising clock edge where pixel_valid is 1;
// with pixel_valid at 0 the renderer's scan state and icon_on hold.
// scan_state is a debug view of the scan FSM.
interface lives_icon_renderer_if;
   import hud_pkg::*;

   logic        pixel_valid;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        frame_start;
   logic        life_lost;
   logic        life_gain;
   logic [2:0]  font_addr;
   glyph_row_t  font_data;
   logic        icon_on;
   logic [2:0]  lives;
   logic        game_over;
   lives_scan_t scan_state;

   modport master (
      output pixel_valid, DrawX, DrawY, frame_start, life_lost, life_gain,
             font_data,
      input  font_addr, icon_on, lives, game_over, scan_state
   );

   modport slave (
      input  pixel_valid, DrawX, DrawY, frame_start, life_lost, life_gain,
             font_data,
      output font_addr, icon_on, lives, game_over, scan_state
   );

endinterface

// File: rtl/lives_counter.sv
// Saturating lives counter with frame-latched display count.
//   clk, rst_n           : clock, asynchronous active-low reset
//   life_lost/life_gain  : one-cycle pulses; both together cancel
//   frame_start          : loads shown from the post-update count
//   lives, game_over     : registered count and (lives == 0)
//   shown                : count used by the renderer this frame
//   blink_off            : suppress the icons (single-life blink)
// Optional feature macro: LIVES_BLINK_EN (5-bit frame counter; with one
// life shown the icon is hidden while counter bit 4 is set).
module lives_counter #(
   parameter int MAX_LIVES  = 5,
   parameter int INIT_LIVES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       life_lost,
   input  logic       life_gain,
   input  logic       frame_start,
   output logic [2:0] lives,
   output logic       game_over,
   output logic [2:0] shown,
   output logic       blink_off
);

   logic [2:0] lives_q;
   logic [2:0] lives_d;
   logic       game_over_q;
   logic [2:0] shown_q;

   always_comb begin
      lives_d = lives_q;
      if (life_lost && !life_gain && (lives_q != 3'd0)) begin
         lives_d = lives_q - 3'd1;
      end else if (life_gain && !life_lost && (lives_q != 3'(MAX_LIVES))) begin
         lives_d = lives_q + 3'd1;
      end
   end

   // shown loads the post-update value so a pulse coinciding with
   // frame_start is reflected in the new frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lives_q     <= 3'(INIT_LIVES);
         game_over_q <= (INIT_LIVES == 0);
         shown_q     <= 3'(INIT_LIVES);
      end else begin
         lives_q     <= lives_d;
         game_over_q <= (lives_d == 3'd0);
         if (frame_start) begin
            shown_q <= lives_d;
         end
      end
   end

`ifdef LIVES_BLINK_EN
   logic [4:0] frame_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= 5'd0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 5'd1;
      end
   end

   assign blink_off = (shown_q == 3'd1) && frame_cnt[4];
`else
   assign blink_off = 1'b0;
`endif

   assign lives     = lives_q;
   assign game_over = game_over_q;
   assign shown     = shown_q;

endmodule

// File: rtl/lives_icon_renderer.sv
// Lives-icon renderer: walks the HUD band, fetches glyph rows from an
// external combinational ROM and serialises them into icon_on, one icon
// per displayed life, left to right.
//   Clk, Reset_n : pixel clock, asynchronous active-low reset
//   bus (slave)  : pixel scan inputs, life pulses, frame_start, ROM port
//                  (font_addr out / font_data in), icon_on, lives,
//                  game_over, scan_state (FSM debug view)
// Optional feature macro: LIVES_BLINK_EN (handled in lives_counter).
// Scan timeline on a band line: DrawX = ICON_X0-2 registers the ROM
// address, ICON_X0-1 captures the row, ICON_X0 is the first drawn pixel;
// icon_on lags its DrawX by one valid cycle.
module lives_icon_renderer
   import hud_pkg::*;
#(
   parameter int MAX_LIVES  = 5,
   parameter int INIT_LIVES = 3,
   parameter int ICON_X0    = 16,
   parameter int ICON_Y0    = 464,
   parameter int ICON_PITCH = 10
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   lives_icon_renderer_if.slave  bus
);

   localparam int GAP_LEN = ICON_PITCH - GLYPH_W;

   logic [2:0] lives_w;
   logic       game_over_w;
   logic [2:0] shown;
   logic       blink_off;

   lives_counter #(
      .MAX_LIVES  (MAX_LIVES),
      .INIT_LIVES (INIT_LIVES)
   ) u_counter (
      .clk         (Clk),
      .rst_n       (Reset_n),
      .life_lost   (bus.life_lost),
      .life_gain   (bus.life_gain),
      .frame_start (bus.frame_start),
      .lives       (lives_w),
      .game_over   (game_over_w),
      .shown       (shown),
      .blink_off   (blink_off)
   );

   lives_scan_t state_q, state_d;
   logic [2:0]  font_addr_q, font_addr_d;
   glyph_row_t  row_q, row_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [2:0]  icon_idx_q, icon_idx_d;
   logic [9:0]  gap_cnt_q, gap_cnt_d;
   logic        icon_on_q, icon_on_d;

   logic [10:0] y_ext;
   logic        in_band;
   logic        at_fetch_x;
   logic        last_slot;

   // One extra bit so ICON_Y0 + GLYPH_H cannot wrap near the 10-bit top.
   assign y_ext      = {1'b0, bus.DrawY};
   assign in_band    = (y_ext >= 11'(ICON_Y0)) && (y_ext < 11'(ICON_Y0 + GLYPH_H));
   assign at_fetch_x = (bus.DrawX == 10'(ICON_X0 - 2));
   assign last_slot  = (icon_idx_q == 3'(MAX_LIVES - 1));

   always_comb begin
      state_d     = state_q;
      font_addr_d = font_addr_q;
      row_d       = row_q;
      bit_cnt_d   = bit_cnt_q;
      icon_idx_d  = icon_idx_q;
      gap_cnt_d   = gap_cnt_q;
      icon_on_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (in_band && at_fetch_x) begin
               state_d     = FETCH;
               font_addr_d = 3'(bus.DrawY - 10'(ICON_Y0));
            end
         end

         FETCH: begin
            row_d      = bus.font_data;
            bit_cnt_d  = 3'd0;
            icon_idx_d = 3'd0;
            state_d    = DRAW;
         end

         DRAW: begin
            icon_on_d = row_q[3'(GLYPH_W - 1) - bit_cnt_q] &&
                        (icon_idx_q < shown) && !blink_off;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(GLYPH_W - 1)) begin
               bit_cnt_d = 3'd0;
               if (ICON_PITCH > GLYPH_W) begin
                  state_d   = GAP;
                  gap_cnt_d = 10'd0;
               end else if (last_slot) begin
                  state_d = IDLE;
               end else begin
                  icon_idx_d = icon_idx_q + 3'd1;
               end
            end
         end

         GAP: begin
            gap_cnt_d = gap_cnt_q + 10'd1;
            if (gap_cnt_q == 10'(GAP_LEN - 1)) begin
               gap_cnt_d = 10'd0;
               if (last_slot) begin
                  state_d = IDLE;
               end else begin
                  icon_idx_d = icon_idx_q + 3'd1;
                  bit_cnt_d  = 3'd0;
                  state_d    = DRAW;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Everything, icon_on included, freezes while pixel_valid is low.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         font_addr_q <= 3'd0;
         row_q       <= '0;
         bit_cnt_q   <= 3'd0;
         icon_idx_q  <= 3'd0;
         gap_cnt_q   <= 10'd0;
         icon_on_q   <= 1'b0;
      end else if (bus.pixel_valid) begin
         state_q     <= state_d;
         font_addr_q <= font_addr_d;
         row_q       <= row_d;
         bit_cnt_q   <= bit_cnt_d;
         icon_idx_q  <= icon_idx_d;
         gap_cnt_q   <= gap_cnt_d;
         icon_on_q   <= icon_on_d;
      end
   end

   assign bus.font_addr  = font_addr_q;
   assign bus.icon_on    = icon_on_q;
   assign bus.lives      = lives_w;
   assign bus.game_over  = game_over_w;
   assign bus.scan_state = state_q;

endmodule

// File: tb/tb_lives_icon_renderer.sv
// Bench for lives_icon_renderer with default parameters and a local
// glyph ROM model driving font_data.
module tb_lives_icon_renderer;
   import hud_pkg::*;

   localparam int MAXL  = 5;
   localparam int X0    = 16;
   localparam int Y0    = 464;
   localparam int PITCH = 10;
   localparam int LINE_W = 80;

   logic Clk;
   logic Reset_n;

   lives_icon_renderer_if bus ();

   lives_icon_renderer #(
      .MAX_LIVES  (MAXL),
      .INIT_LIVES (3),
      .ICON_X0    (X0),
      .ICON_Y0    (Y0),
      .ICON_PITCH (PITCH)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // glyph ROM model
   logic [7:0] glyph_rom [8];
   assign bus.font_data = glyph_rom[bus.font_addr];

   // clock / reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // scoreboard state
   logic [0:0] exp_q [$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         shown_m = 3;
   logic       last_exp = 1'b0;

   typedef struct {
      logic       lost;
      logic       gain;
      logic       frame;
      logic [2:0] exp_lives;
      logic       exp_go;
      logic       scan;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic model_pix(input int x, input int y);
      int dx;
      int slot;
      int col;
      logic [7:0] r;
      if (y < Y0 || y > Y0 + 7) return 1'b0;
      dx = x - X0;
      if (dx < 0 || dx >= MAXL * PITCH) return 1'b0;
      slot = dx / PITCH;
      col  = dx % PITCH;
      if (col >= 8) return 1'b0;
      if (slot >= shown_m) return 1'b0;
      r = glyph_rom[y - Y0];
      return r[7 - col];
   endfunction

   task automatic compare_out(input string name);
      logic [0:0] e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got %0d expected <queue empty>", name, bus.icon_on);
      end else begin
         e = exp_q.pop_front();
         check(name, int'(bus.icon_on), int'(e));
      end
   endtask

   // driver tasks
   task automatic drive_pix(input int x, input int y);
      bus.pixel_valid = 1'b1;
      bus.DrawX = 10'(x);
      bus.DrawY = 10'(y);
      last_exp = model_pix(x, y);
      exp_q.push_back(last_exp);
      @(posedge Clk);
      #1;
      compare_out($sformatf("icon_on y=%0d x=%0d", y, x));
      if (x == X0 - 2 && y >= Y0 && y <= Y0 + 7)
         check($sformatf("font_addr y=%0d", y), int'(bus.font_addr), y - Y0);
   endtask

   task automatic stall_cycle();
      bus.pixel_valid = 1'b0;
      exp_q.push_back(last_exp);
      @(posedge Clk);
      #1;
      compare_out("icon_on stall");
   endtask

   task automatic scan_line(input int y, input int stall_x);
      for (int x = 0; x < LINE_W; x++) begin
         if (x == stall_x) repeat (4) stall_cycle();
         drive_pix(x, y);
      end
      bus.pixel_valid = 1'b0;
   endtask

   task automatic scan_band();
      for (int y = Y0; y < Y0 + 8; y++) scan_line(y, -1);
   endtask

   task automatic pulse(input logic lost, input logic gain, input logic frame);
      bus.pixel_valid = 1'b1;
      bus.DrawX = 10'd0;
      bus.DrawY = 10'd0;
      bus.life_lost = lost;
      bus.life_gain = gain;
      bus.frame_start = frame;
      @(posedge Clk);
      #1;
      bus.life_lost = 1'b0;
      bus.life_gain = 1'b0;
      bus.frame_start = 1'b0;
      bus.pixel_valid = 1'b0;
      last_exp = 1'b0;
   endtask

   initial begin
      glyph_rom[0] = 8'b00111100;
      glyph_rom[1] = 8'b01111110;
      glyph_rom[2] = 8'b00011111;
      glyph_rom[3] = 8'b11111111;
      glyph_rom[4] = 8'b11111110;
      glyph_rom[5] = 8'b01111100;
      glyph_rom[6] = 8'b00111000;
      glyph_rom[7] = 8'b00010000;

      //            lost  gain  frame lives go    scan
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 1'b1};

      Reset_n = 1'b0;
      bus.pixel_valid = 1'b0;
      bus.DrawX = 10'd0;
      bus.DrawY = 10'd0;
      bus.frame_start = 1'b0;
      bus.life_lost = 1'b0;
      bus.life_gain = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      @(posedge Clk);
      #1;

      // reset state
      check("reset lives", int'(bus.lives), 3);
      check("reset game_over", int'(bus.game_over), 0);
      check("reset icon_on", int'(bus.icon_on), 0);
      check("reset font_addr", int'(bus.font_addr), 0);
      check("reset scan_state", int'(bus.scan_state), int'(IDLE));

      // default rendering: row 2 plus lines just outside the band
      scan_line(Y0 + 2, -1);
      scan_line(Y0 - 1, -1);
      scan_line(Y0 + 8, -1);
      scan_band();

      // counter vectors
      for (int i = 0; i < 13; i++) begin
         pulse(vecs[i].lost, vecs[i].gain, vecs[i].frame);
         check($sformatf("vec%0d lives", i), int'(bus.lives), int'(vecs[i].exp_lives));
         check($sformatf("vec%0d game_over", i), int'(bus.game_over), int'(vecs[i].exp_go));
         if (vecs[i].frame) shown_m = int'(vecs[i].exp_lives);
         if (vecs[i].scan) scan_band();
      end

      // mid-frame loss: display keeps the latched count until frame_start
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b0, 1'b1);
      shown_m = 3;
      check("mid lives before", int'(bus.lives), 3);
      scan_line(Y0, -1);
      pulse(1'b1, 1'b0, 1'b0);
      check("mid lives after loss", int'(bus.lives), 2);
      scan_line(Y0 + 2, -1);
      pulse(1'b0, 1'b0, 1'b1);
      shown_m = 2;
      scan_line(Y0 + 2, -1);

      // stall mid-icon on row 0
      scan_line(Y0, 19);

      // reset pulsed mid-icon on row 1
      for (int x = 0; x < 20; x++) drive_pix(x, Y0 + 1);
      bus.pixel_valid = 1'b1;
      bus.DrawX = 10'd20;
      #2;
      Reset_n = 1'b0;
      #1;
      check("async reset icon_on", int'(bus.icon_on), 0);
      check("async reset scan_state", int'(bus.scan_state), int'(IDLE));
      check("async reset lives", int'(bus.lives), 3);
      exp_q.delete();
      bus.pixel_valid = 1'b0;
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      shown_m = 3;
      last_exp = 1'b0;
      scan_line(Y0 + 1, -1);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lives_icon_renderer.md
# lives_icon_renderer

Reads the 8x8 lives-icon glyph ROM (`livefont`) scanline by scanline and serialises its rows into a per-pixel `icon_on` stream: one icon per remaining life, drawn left to right in a fixed HUD band. Also owns the lives counter. It takes loss and gain pulses from game logic and latches the displayed count at frame start so icons never tear mid-frame. It sits between the VGA pixel-coordinate generator and the colour mapper; the glyph ROM sits beside it as a combinational lookup.

## Interface
- `MAX_LIVES`, 5: icon slots and saturation ceiling (1..7).
- `INIT_LIVES`, 3: count loaded at reset.
- `ICON_X0`, 16: DrawX of the first icon's leftmost pixel (≥2).
- `ICON_Y0`, 464: DrawY of glyph row 0.
- `ICON_PITCH`, 10: pixels between successive icon origins (≥8).

Ports:
- `Clk`, input, 1: pixel-rate clock.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `pixel_valid`, input, 1: DrawX/DrawY advance this cycle; all scan logic is gated by it.
- `DrawX`, input, 10: current pixel column.
- `DrawY`, input, 10: current pixel row.
- `frame_start`, input, 1: one-cycle pulse at the start of vertical blank.
- `life_lost`, input, 1: one-cycle pulse; decrement.
- `life_gain`, input, 1: one-cycle pulse; increment.
- `font_addr`, output, 3: glyph row to the ROM. Registered.
- `font_data`, input, 8: ROM row; MSB is the leftmost pixel.
- `icon_on`, output, 1: registered pixel flag for the previous valid DrawX.
- `lives`, output, 3: live count, updated immediately.
- `game_over`, output, 1: high while `lives == 0`.

## Operation
- Counter `lives`:
  - `life_lost` alone decrements, saturating at 0.
  - `life_gain` alone increments, saturating at `MAX_LIVES`.
  - Both pulses in the same cycle cause no change.
- `game_over` is a registered output equal to `lives == 0`.
- `shown` is the display count. It loads from `lives` on `frame_start`; a change on the same cycle as `frame_start` is taken in that load.
- Scan FSM states: IDLE, FETCH, DRAW, GAP. It transitions only on cycles where `pixel_valid` is high.
  - IDLE→FETCH: `DrawY` is in [`ICON_Y0`, `ICON_Y0`+7] and `DrawX == ICON_X0-2`. Drive `font_addr <= DrawY - ICON_Y0`, truncated to 3 bits.
  - FETCH→DRAW: capture `row <= font_data`, clear `bit_cnt` and `icon_idx`.
  - DRAW: `icon_on <= row[7-bit_cnt] && (icon_idx < shown)`. At `bit_cnt == 7`:
    - go to GAP if `ICON_PITCH > 8`;
    - else if `icon_idx == MAX_LIVES-1`, go to IDLE;
    - else increment `icon_idx` and stay in DRAW.
  - GAP: `icon_on <= 0` for `ICON_PITCH-8` pixels. Then increment `icon_idx` and return to DRAW, or go to IDLE after the last slot.
- Outside DRAW, `icon_on <= 0` on every valid pixel.
- When `pixel_valid` is low, every register holds, including `icon_on`.
- Coordinates outside the band never leave IDLE.

## Timing
- Reset values:
  - `lives = shown = INIT_LIVES`
  - `game_over = (INIT_LIVES == 0)`
  - `icon_on = 0`
  - `font_addr = 0`
  - FSM = IDLE
  - all counters 0
- Assertion of `Reset_n` mid-line aborts the line immediately. The next line restarts cleanly from IDLE.
- Latency from a valid `DrawX` to its `icon_on` is 1 valid cycle.
- ROM read latency: `font_addr` is registered in cycle t; `font_data` is sampled in cycle t+1.
- `lives` and `game_over` update 1 cycle after the pulse.
- Icons follow a `lives` change from the frame after the next `frame_start`.

## Configuration
- `LIVES_BLINK_EN` defined:
  - A 5-bit frame counter increments on each `frame_start`.
  - When `shown == 1`, the single icon is suppressed while the counter's bit 4 is 1, giving a 16-frame-on / 16-frame-off blink.
  - The counter resets to 0.
- `LIVES_BLINK_EN` undefined: no counter; icons are always drawn.

## Structure
- Shared package `hud_pkg`:
  - enum `lives_scan_t` (IDLE/FETCH/DRAW/GAP);
  - `GLYPH_W = 8`, `GLYPH_H = 8`;
  - typedef `glyph_row_t` (`logic [7:0]`).
- Sub-module `lives_counter`: the saturating counter, `game_over`, and the `frame_start` latch to `shown`. The renderer instantiates it.
- The renderer does not instantiate `livefont`; the top level wires `font_addr`/`font_data`.

## Test plan
- Reset with defaults:
  - `lives = 3`, `game_over = 0`, `icon_on = 0`.
  - On `DrawY = 466` (glyph row 2, pattern 00011111), `icon_on` for `DrawX` 16..23 is 0,0,0,1,1,1,1,1, one cycle late.
  - Icon 2 starts at `DrawX = 26`; `DrawX` 24..25 give 0.
  - Slots 3 and 4 give all 0.
- Three `life_lost` pulses, then `frame_start`:
  - `lives = 0`, `game_over = 1`.
  - No `icon_on` anywhere in the band.
  - A fourth `life_lost` leaves `lives = 0`.
- `life_lost` and `life_gain` in the same cycle at `lives = 3`: `lives` stays 3.
- Three `life_gain` pulses from 3: `lives = 5`; then `frame_start` shows 5 icons.
- `life_lost` mid-frame: icons on this frame's remaining lines still show 3; after `frame_start`, 2 are shown.
- Stall and reset:
  - `pixel_valid` held low for 4 cycles mid-icon on row 0 (00111100): output resumes at the same bit, and the pattern is unbroken when counted over valid cycles only.
  - `Reset_n` pulsed mid-icon: `icon_on = 0` immediately, and the next band line renders correctly.
